nv_nvdla_cacc_qreq_ctrl: RTL and testbench

//  Q-Channel power controller directly upstream of the CACC Q-Channel wrapper: drives its qreqn, consumes qacceptn/qdeny.

---
 rtl/nv_nvdla_cacc_qctrl_pkg.sv | 23 ++
 rtl/nv_nvdla_cacc_qreq_ctrl_if.sv | 13 +
 rtl/nv_nvdla_cacc_qctrl_idle_cnt.sv | 39 +++
 rtl/nv_nvdla_cacc_qreq_ctrl.sv | 120 ++++++++++++
 tb/tb_nv_nvdla_cacc_qreq_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nv_nvdla_cacc_qctrl_pkg.sv
// Shared definitions for the CACC Q-Channel request controller.
//   Q_* : 3-bit controller state encodings.
//   qctrl_idle / qctrl_wake : decode of the activity sources (CSB request,
//   op_en) and the low-power permission (pwr_allow).
package nv_nvdla_cacc_qctrl_pkg;

  localparam logic [2:0] Q_RUN     = 3'd0;
  localparam logic [2:0] Q_REQ     = 3'd1;
  localparam logic [2:0] Q_STOPPED = 3'd2;
  localparam logic [2:0] Q_EXIT    = 3'd3;
  localparam logic [2:0] Q_DENIED  = 3'd4;

  function automatic logic qctrl_idle(input logic csb_req_pvld, input logic op_en,
                                      input logic pwr_allow);
    return !csb_req_pvld && !op_en && pwr_allow;
  endfunction

  function automatic logic qctrl_wake(input logic csb_req_pvld, input logic op_en,
                                      input logic pwr_allow);
    return csb_req_pvld || op_en || !pwr_allow;
  endfunction

endpackage

// File: rtl/nv_nvdla_cacc_qreq_ctrl_if.sv
// Q-Channel bundle between the power controller and the CACC Q-Channel wrapper.
//   qreqn    : request, driven by the controller (0 = request stop)
//   qacceptn : accept, driven by the wrapper (0 = stopped)
//   qdeny    : deny, driven by the wrapper
// master = controller side, slave = wrapper side.
interface nv_nvdla_cacc_qreq_ctrl_if;
  logic qreqn;
  logic qacceptn;
  logic qdeny;

  modport master (output qreqn, input qacceptn, input qdeny);
  modport slave  (input qreqn, output qacceptn, output qdeny);
endinterface

// File: rtl/nv_nvdla_cacc_qctrl_idle_cnt.sv
// Saturating idle-cycle counter for the Q-Channel controller.
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   cnt_en_i    : idle cycle while running; low clears the count
//   idle_done_o : this cycle is the IDLE_CYCLES-th consecutive idle cycle
module nv_nvdla_cacc_qctrl_idle_cnt #(
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rst,
  input  logic cnt_en_i,
  output logic idle_done_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(IDLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Holds at CntMax rather than wrapping; the FSM leaves Q_RUN on that cycle anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (!cnt_en_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idle_done_o = cnt_en_i && (cnt_q == CntMax);

endmodule

// File: rtl/nv_nvdla_cacc_qreq_ctrl.sv
// Q-Channel power controller in front of the CACC Q-Channel wrapper.
// Requests quiescence after IDLE_CYCLES idle cycles, gates the CACC clock while
// stopped and wakes on CSB request, op_en or withdrawal of pwr_allow.
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   csb_req_pvld, op_en, pwr_allow  : activity / permission inputs
//   q_if (master)                   : qreqn out, qacceptn/qdeny in
//   clk_en, q_stopped               : CACC clock enable, stopped indication
//   protocol_err                    : sticky simultaneous accept+deny flag
//   stop_cnt, deny_cnt              : saturating stop/deny statistics
// Macro NVDLA_CACC_QCTRL_STATS_EN enables the statistics counters; without it
// stop_cnt/deny_cnt are tied to zero.
module nv_nvdla_cacc_qreq_ctrl
  import nv_nvdla_cacc_qctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic                        csb_req_pvld,
  input  logic                        op_en,
  input  logic                        pwr_allow,
  nv_nvdla_cacc_qreq_ctrl_if.master   q_if,
  output logic                        clk_en,
  output logic                        q_stopped,
  output logic                        protocol_err,
  output logic [CNT_W-1:0]            stop_cnt,
  output logic [CNT_W-1:0]            deny_cnt
);

  logic [2:0] state_q, state_d;
  logic       qreqn_q, clk_en_q, q_stopped_q, perr_q;
  logic       perr_d;
  logic       idle, wake, idle_done;

  assign idle = qctrl_idle(csb_req_pvld, op_en, pwr_allow);
  assign wake = qctrl_wake(csb_req_pvld, op_en, pwr_allow);

  nv_nvdla_cacc_qctrl_idle_cnt #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_idle_cnt (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .cnt_en_i       ((state_q == Q_RUN) && idle),
    .idle_done_o    (idle_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      Q_EXIT:    if (q_if.qacceptn) state_d = Q_RUN;
      Q_RUN:     if (idle_done) state_d = Q_REQ;
      // Wake is ignored here: qreqn may only rise after accept or deny.
      Q_REQ: begin
        if (!q_if.qacceptn)  state_d = Q_STOPPED;
        else if (q_if.qdeny) state_d = Q_DENIED;
      end
      Q_STOPPED: if (wake) state_d = Q_EXIT;
      Q_DENIED:  if (!q_if.qdeny) state_d = Q_RUN;
      default:   state_d = Q_EXIT;
    endcase
  end

  assign perr_d = perr_q || ((state_q == Q_REQ) && !q_if.qacceptn && q_if.qdeny);

  // Outputs are registered decodes of the next state so they align with state_q.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q     <= Q_EXIT;
      qreqn_q     <= 1'b1;
      clk_en_q    <= 1'b1;
      q_stopped_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      qreqn_q     <= !((state_d == Q_REQ) || (state_d == Q_STOPPED));
      clk_en_q    <= (state_d != Q_STOPPED);
      q_stopped_q <= (state_d == Q_STOPPED);
      perr_q      <= perr_d;
    end
  end

  assign q_if.qreqn   = qreqn_q;
  assign clk_en       = clk_en_q;
  assign q_stopped    = q_stopped_q;
  assign protocol_err = perr_q;

`ifdef NVDLA_CACC_QCTRL_STATS_EN
  logic [CNT_W-1:0] stop_cnt_q, stop_cnt_d, deny_cnt_q, deny_cnt_d;
  logic             stop_evt, deny_evt;

  assign stop_evt = (state_q == Q_REQ) && (state_d == Q_STOPPED);
  assign deny_evt = (state_q == Q_REQ) && (state_d == Q_DENIED);

  always_comb begin
    stop_cnt_d = stop_cnt_q;
    deny_cnt_d = deny_cnt_q;
    if (stop_evt && (stop_cnt_q != '1)) stop_cnt_d = stop_cnt_q + 1'b1;
    if (deny_evt && (deny_cnt_q != '1)) deny_cnt_d = deny_cnt_q + 1'b1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      stop_cnt_q <= '0;
      deny_cnt_q <= '0;
    end else begin
      stop_cnt_q <= stop_cnt_d;
      deny_cnt_q <= deny_cnt_d;
    end
  end

  assign stop_cnt = stop_cnt_q;
  assign deny_cnt = deny_cnt_q;
`else
  assign stop_cnt = '0;
  assign deny_cnt = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cacc_qreq_ctrl.sv
// Randomised scoreboard bench for nv_nvdla_cacc_qreq_ctrl (IDLE_CYCLES=8, CNT_W=8).
// A reference model pushes expected outputs each clock; a monitor pops and compares.
// A small wrapper model answers qreqn with accept/deny after a programmable delay.
module tb_nv_nvdla_cacc_qreq_ctrl;

  localparam int unsigned IDLE = 8;
  localparam int unsigned CW   = 8;
  localparam int          CMAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          csb = 1'b0;
  logic          op_en = 1'b0;
  logic          pwr = 1'b1;
  logic          clk_en, q_stopped, perr;
  logic [CW-1:0] stop_cnt, deny_cnt;

  nv_nvdla_cacc_qreq_ctrl_if q_if ();

  nv_nvdla_cacc_qreq_ctrl #(
    .IDLE_CYCLES (IDLE),
    .CNT_W       (CW)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .csb_req_pvld   (csb),
    .op_en          (op_en),
    .pwr_allow      (pwr),
    .q_if           (q_if),
    .clk_en         (clk_en),
    .q_stopped      (q_stopped),
    .protocol_err   (perr),
    .stop_cnt       (stop_cnt),
    .deny_cnt       (deny_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          qreqn;
    logic          clk_en;
    logic          q_stopped;
    logic          perr;
    logic [CW-1:0] stops;
    logic [CW-1:0] denies;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- reference model ----------------
  // Phase of the power handshake and length of the current idle run.
  typedef enum int {MExit, MRun, MReq, MStop, MDeny} mphase_t;
  mphase_t ph = MExit;
  int      run_len = 0;
  bit      m_err = 1'b0;
  int      m_stops = 0;
  int      m_denies = 0;

  initial begin
    exp_t e;
    bit   idl;
    forever begin
      @(posedge clk);
      idl = !csb && !op_en && pwr;
      if (rst) begin
        ph = MExit; run_len = 0; m_err = 1'b0; m_stops = 0; m_denies = 0;
      end else begin
        case (ph)
          MExit: if (q_if.qacceptn) begin ph = MRun; run_len = 0; end
          MRun: begin
            run_len = idl ? run_len + 1 : 0;
            if (run_len == IDLE) ph = MReq;
          end
          MReq: begin
            if (!q_if.qacceptn) begin
              ph = MStop;
              if (m_stops < CMAX) m_stops++;
              if (q_if.qdeny) m_err = 1'b1;
            end else if (q_if.qdeny) begin
              ph = MDeny;
              if (m_denies < CMAX) m_denies++;
            end
          end
          MStop: if (!idl) ph = MExit;
          MDeny: if (!q_if.qdeny) begin ph = MRun; run_len = 0; end
          default: ph = MExit;
        endcase
      end
      e.qreqn     = !(ph == MReq || ph == MStop);
      e.clk_en    = (ph != MStop);
      e.q_stopped = (ph == MStop);
      e.perr      = m_err;
`ifdef NVDLA_CACC_QCTRL_STATS_EN
      e.stops  = CW'(m_stops);
      e.denies = CW'(m_denies);
`else
      e.stops  = '0;
      e.denies = '0;
`endif
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int act, input int exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("qreqn", int'(q_if.qreqn), int'(e.qreqn));
        chk("clk_en", int'(clk_en), int'(e.clk_en));
        chk("q_stopped", int'(q_stopped), int'(e.q_stopped));
        chk("protocol_err", int'(perr), int'(e.perr));
        chk("stop_cnt", int'(stop_cnt), int'(e.stops));
        chk("deny_cnt", int'(deny_cnt), int'(e.denies));
      end
    end
  end

  // ---------------- wrapper model ----------------
  // w_mode: 0 accept, 1 deny, 2 accept+deny together (protocol error).
  int w_mode = 0;
  int w_delay = 17;
  bit w_rand = 1'b0;

  initial begin
    int rcnt = 0;
    int wcnt = 0;
    q_if.qacceptn = 1'b0;
    q_if.qdeny    = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        // Wrapper reset lands in STOP, then re-accepts.
        rcnt++;
        wcnt = 0;
        q_if.qdeny    = 1'b0;
        q_if.qacceptn = (rcnt >= 2);
      end else begin
        rcnt = 0;
        if (!q_if.qreqn) begin
          if (q_if.qacceptn && !q_if.qdeny) begin
            wcnt++;
            if (wcnt >= w_delay) begin
              wcnt = 0;
              case (w_mode)
                0:       q_if.qacceptn = 1'b0;
                1:       q_if.qdeny = 1'b1;
                default: begin q_if.qacceptn = 1'b0; q_if.qdeny = 1'b1; end
              endcase
              if (w_rand) begin
                w_mode  = int'($urandom_range(0, 1));
                w_delay = int'($urandom_range(1, 20));
              end
            end
          end
        end else begin
          wcnt = 0;
          if (!q_if.qacceptn || q_if.qdeny) begin
            q_if.qacceptn = 1'b1;
            q_if.qdeny    = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic c, input logic o, input logic p, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      csb = c; op_en = o; pwr = p;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // Full idle window, accept after 17 cycles, stop.
    drive(0, 0, 1, 40);
    // Wake from stopped and keep busy.
    drive(1, 0, 1, 1);
    drive(0, 1, 1, 5);
    // Idle run broken one short of the threshold: no request.
    drive(0, 0, 1, 7);
    drive(1, 0, 1, 1);
    drive(0, 0, 1, 7);
    drive(0, 1, 1, 2);
    // Wake raised during the request is held off until accept.
    drive(0, 0, 1, 8);
    drive(1, 0, 1, 30);
    // pwr_allow withdrawn: wakes and blocks entry.
    drive(0, 0, 1, 30);
    drive(0, 0, 0, 25);
    drive(1, 0, 1, 2);
    // Deny path, then a full new window before the next request.
    w_mode = 1;
    drive(0, 0, 1, 30);
    w_mode = 0;
    drive(0, 0, 1, 40);
    drive(0, 1, 1, 3);
    // Accept and deny together: sticky error until reset.
    w_mode = 2;
    drive(0, 0, 1, 30);
    w_mode = 0;
    drive(0, 1, 1, 50);
    drive(0, 0, 1, 50);
    do_reset();
    // Randomised traffic with random wrapper responses and occasional resets.
    w_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        drive(logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 19) == 0),
              logic'($urandom_range(0, 24) != 0), 1);
      end
    end
    drive(0, 0, 1, 5);
    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
